// File: rtl/modulepwm_multich_if.sv
`default_nettype none
// ============================================================================
// modulepwm_multich_if
// AXI4-Lite bus bundle for the modulepwm_multich register slave.
// Revision: 1.0
// ============================================================================
interface modulepwm_multich_if #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6
);
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic [2:0]                      S_AXI_AWPROT;
   logic                            S_AXI_AWVALID;
   logic                            S_AXI_AWREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                            S_AXI_WVALID;
   logic                            S_AXI_WREADY;
   logic [1:0]                      S_AXI_BRESP;
   logic                            S_AXI_BVALID;
   logic                            S_AXI_BREADY;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
   logic [2:0]                      S_AXI_ARPROT;
   logic                            S_AXI_ARVALID;
   logic                            S_AXI_ARREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
   logic [1:0]                      S_AXI_RRESP;
   logic                            S_AXI_RVALID;
   logic                            S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      output S_AXI_RREADY
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      input  S_AXI_RREADY
   );
endinterface
`default_nettype wire

// File: rtl/modulepwm_multich.sv
`default_nettype none
// ============================================================================
// modulepwm_multich
// NUM_CH PWM channels on one shared counter; double-buffered period/duty over
// AXI4-Lite. Optional macro MODULEPWM_IRQ_EN enables STATUS.WRAP and irq.
// Revision: 1.0
// ============================================================================
module modulepwm_multich #(
   parameter int NUM_CH             = 4,
   parameter int CNT_WIDTH          = 16,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6
) (
   input  wire logic              S_AXI_ACLK,
   input  wire logic              S_AXI_ARESET,
   modulepwm_multich_if.slave     s_axi,
   output logic [NUM_CH-1:0]      pwm_out,
   output logic                   irq
);

   localparam int DW     = C_S_AXI_DATA_WIDTH;
   localparam int WORD_W = C_S_AXI_ADDR_WIDTH - 2;
   localparam int STRB_W = DW / 8;
   localparam logic [WORD_W-1:0] A_CTRL   = WORD_W'(0);
   localparam logic [WORD_W-1:0] A_PERIOD = WORD_W'(1);
   localparam logic [WORD_W-1:0] A_STATUS = WORD_W'(2);
   localparam logic [WORD_W-1:0] A_COUNT  = WORD_W'(3);
`ifdef MODULEPWM_IRQ_EN
   localparam logic [1:0] CTRL_MASK = 2'b11;
`else
   localparam logic [1:0] CTRL_MASK = 2'b01;
`endif

   typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
   typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

   w_state_t              w_state_q, w_state_d;
   r_state_t              r_state_q, r_state_d;
   logic                  bvalid_q, bvalid_d;
   logic                  rvalid_q, rvalid_d;
   logic [DW-1:0]         rdata_q, rdata_d;

   logic [1:0]            ctrl_q, ctrl_d;
   logic [CNT_WIDTH-1:0]  period_sh_q, period_sh_d;
   logic [CNT_WIDTH-1:0]  duty_sh_q [NUM_CH];
   logic [CNT_WIDTH-1:0]  duty_sh_d [NUM_CH];
   logic                  status_q, status_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]  act_period_q, act_period_d;
   logic [CNT_WIDTH-1:0]  act_duty_q [NUM_CH];
   logic [CNT_WIDTH-1:0]  act_duty_d [NUM_CH];
   logic [NUM_CH-1:0]     pwm_q, pwm_d;
   logic                  irq_q, irq_d;

   logic                  aw_hs, ar_hs, en, wrap;
   logic [WORD_W-1:0]     wr_word, rd_word;
   logic [DW-1:0]         wr_old, wr_new, rd_val;
   logic                  unused_bits;

   assign wr_word = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign rd_word = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

   // Ready is a same-cycle pulse so a read can complete every two cycles.
   assign aw_hs = (w_state_q == W_IDLE) && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID
                  && !S_AXI_ARESET;
   assign ar_hs = (r_state_q == R_IDLE) && s_axi.S_AXI_ARVALID && !S_AXI_ARESET;

   assign s_axi.S_AXI_AWREADY = aw_hs;
   assign s_axi.S_AXI_WREADY  = aw_hs;
   assign s_axi.S_AXI_BVALID  = bvalid_q;
   assign s_axi.S_AXI_BRESP   = 2'b00;
   assign s_axi.S_AXI_ARREADY = ar_hs;
   assign s_axi.S_AXI_RVALID  = rvalid_q;
   assign s_axi.S_AXI_RDATA   = rdata_q;
   assign s_axi.S_AXI_RRESP   = 2'b00;
   assign pwm_out             = pwm_q;
   assign irq                 = irq_q;

   assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                          s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0], wr_new};

   assign en   = ctrl_q[0];
   assign wrap = en && (cnt_q == act_period_q);

   always_comb begin
      w_state_d = w_state_q;
      bvalid_d  = bvalid_q;
      case (w_state_q)
         W_IDLE: if (aw_hs) begin
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
         end
         W_RESP: if (s_axi.S_AXI_BREADY) begin
            w_state_d = W_IDLE;
            bvalid_d  = 1'b0;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      case (r_state_q)
         R_IDLE: if (ar_hs) begin
            r_state_d = R_DATA;
            rvalid_d  = 1'b1;
            rdata_d   = rd_val;
         end
         R_DATA: if (s_axi.S_AXI_RREADY) begin
            r_state_d = R_IDLE;
            rvalid_d  = 1'b0;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      rd_val = '0;
      if (rd_word == A_CTRL)   rd_val = DW'(ctrl_q);
      if (rd_word == A_PERIOD) rd_val = DW'(period_sh_q);
      if (rd_word == A_STATUS) rd_val = DW'(status_q);
      if (rd_word == A_COUNT)  rd_val = DW'(cnt_q);
      for (int k = 0; k < NUM_CH; k++)
         if (rd_word == WORD_W'(4 + k)) rd_val = DW'(duty_sh_q[k]);
   end

   // Byte-strobe merge against the current contents of the addressed register.
   always_comb begin
      wr_old = '0;
      if (wr_word == A_CTRL)   wr_old = DW'(ctrl_q);
      if (wr_word == A_PERIOD) wr_old = DW'(period_sh_q);
      for (int k = 0; k < NUM_CH; k++)
         if (wr_word == WORD_W'(4 + k)) wr_old = DW'(duty_sh_q[k]);
      wr_new = wr_old;
      for (int b = 0; b < STRB_W; b++)
         if (s_axi.S_AXI_WSTRB[b]) wr_new[8*b +: 8] = s_axi.S_AXI_WDATA[8*b +: 8];
   end

   always_comb begin
      ctrl_d      = ctrl_q;
      period_sh_d = period_sh_q;
      duty_sh_d   = duty_sh_q;
      if (aw_hs) begin
         if (wr_word == A_CTRL)   ctrl_d      = wr_new[1:0] & CTRL_MASK;
         if (wr_word == A_PERIOD) period_sh_d = wr_new[CNT_WIDTH-1:0];
         for (int k = 0; k < NUM_CH; k++)
            if (wr_word == WORD_W'(4 + k)) duty_sh_d[k] = wr_new[CNT_WIDTH-1:0];
      end
`ifdef MODULEPWM_IRQ_EN
      status_d = status_q;
      if (aw_hs && (wr_word == A_STATUS) && s_axi.S_AXI_WSTRB[0] && s_axi.S_AXI_WDATA[0])
         status_d = 1'b0;
      if (wrap)
         status_d = 1'b1;
      irq_d = status_q & ctrl_q[1];
`else
      status_d = 1'b0;
      irq_d    = 1'b0;
`endif
   end

   // Actives follow the shadows while stopped and latch them only at wrap.
   always_comb begin
      cnt_d        = (en && !wrap) ? cnt_q + CNT_WIDTH'(1) : '0;
      act_period_d = act_period_q;
      act_duty_d   = act_duty_q;
      if (!en || wrap) begin
         act_period_d = period_sh_q;
         act_duty_d   = duty_sh_q;
      end
      pwm_d = '0;
      for (int k = 0; k < NUM_CH; k++)
         pwm_d[k] = en && (cnt_q < act_duty_q[k]);
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         w_state_q    <= W_IDLE;
         r_state_q    <= R_IDLE;
         bvalid_q     <= 1'b0;
         rvalid_q     <= 1'b0;
         rdata_q      <= '0;
         ctrl_q       <= '0;
         period_sh_q  <= '0;
         status_q     <= 1'b0;
         cnt_q        <= '0;
         act_period_q <= '0;
         pwm_q        <= '0;
         irq_q        <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            duty_sh_q[k]  <= '0;
            act_duty_q[k] <= '0;
         end
      end else begin
         w_state_q    <= w_state_d;
         r_state_q    <= r_state_d;
         bvalid_q     <= bvalid_d;
         rvalid_q     <= rvalid_d;
         rdata_q      <= rdata_d;
         ctrl_q       <= ctrl_d;
         period_sh_q  <= period_sh_d;
         status_q     <= status_d;
         cnt_q        <= cnt_d;
         act_period_q <= act_period_d;
         pwm_q        <= pwm_d;
         irq_q        <= irq_d;
         for (int k = 0; k < NUM_CH; k++) begin
            duty_sh_q[k]  <= duty_sh_d[k];
            act_duty_q[k] <= act_duty_d[k];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_modulepwm_multich.sv
`default_nettype none
// ============================================================================
// tb_modulepwm_multich
// Directed bench for modulepwm_multich (NUM_CH=4, CNT_WIDTH=16).
// Revision: 1.0
// ============================================================================
module tb_modulepwm_multich;
   localparam int NUM_CH    = 4;
   localparam int CNT_WIDTH = 16;
`ifdef MODULEPWM_IRQ_EN
   localparam logic HAS_IRQ = 1'b1;
`else
   localparam logic HAS_IRQ = 1'b0;
`endif
   localparam logic [5:0] A_CTRL = 6'h00, A_PERIOD = 6'h04, A_STATUS = 6'h08,
                          A_COUNT = 6'h0C, A_DUTY0 = 6'h10, A_DUTY1 = 6'h14,
                          A_DUTY2 = 6'h18, A_DUTY3 = 6'h1C;

   logic clk = 1'b0;
   logic rst;
   logic [NUM_CH-1:0] pwm_out;
   logic irq;
   int cyc = 0;
   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   modulepwm_multich_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) bus ();

   modulepwm_multich #(
      .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH),
      .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)
   ) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .s_axi(bus),
      .pwm_out(pwm_out), .irq(irq)
   );

   typedef struct {
      logic        wr;
      logic [5:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;
   vec_t vt[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic timeout(input string name);
      n_total++;
      $display("FAIL timeout %s: no response within 50 cycles", name);
   endtask

   task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      bus.S_AXI_AWADDR = a; bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s;
      bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b1;
      #1;
      while (!bus.S_AXI_AWREADY && n < 50) begin tick(); n++; end
      if (!bus.S_AXI_AWREADY) timeout("aw_handshake");
      tick();
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      n = 0;
      while (!bus.S_AXI_BVALID && n < 50) begin tick(); n++; end
      if (!bus.S_AXI_BVALID) timeout("bvalid");
      check($sformatf("bresp addr 0x%02h", a), 32'(bus.S_AXI_BRESP), 32'd0);
      tick();
      bus.S_AXI_BREADY = 1'b0;
   endtask

   task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
      int n = 0;
      bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b1;
      #1;
      while (!bus.S_AXI_ARREADY && n < 50) begin tick(); n++; end
      if (!bus.S_AXI_ARREADY) timeout("ar_handshake");
      tick();
      bus.S_AXI_ARVALID = 1'b0;
      n = 0;
      while (!bus.S_AXI_RVALID && n < 50) begin tick(); n++; end
      if (!bus.S_AXI_RVALID) timeout("rvalid");
      d = bus.S_AXI_RDATA;
      check($sformatf("rresp addr 0x%02h", a), 32'(bus.S_AXI_RRESP), 32'd0);
      tick();
      bus.S_AXI_RREADY = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [5:0] a, input logic [31:0] exp);
      logic [31:0] d;
      axi_read(a, d);
      check(name, d, exp);
   endtask

   // Bounded wait until (cyc - base + off) mod m equals target.
   task automatic wait_phase(input int base, input int off, input int m, input int target);
      int n = 0;
      while (((cyc - base + off) % m) != target && n < 50) begin tick(); n++; end
      if (((cyc - base + off) % m) != target) timeout("wait_phase");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int duty_now;
      logic [31:0] d;

      rst = 1'b1;
      bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_WDATA = '0;
      bus.S_AXI_WSTRB = '0; bus.S_AXI_BREADY = 1'b0; bus.S_AXI_ARADDR = '0;
      bus.S_AXI_ARPROT = '0; bus.S_AXI_RREADY = 1'b0;
      bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
      repeat (5) tick();
      check("reset awready", 32'(bus.S_AXI_AWREADY), 32'd0);
      check("reset arready", 32'(bus.S_AXI_ARREADY), 32'd0);
      check("reset bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
      check("reset rvalid", 32'(bus.S_AXI_RVALID), 32'd0);
      check("reset pwm_out", 32'(pwm_out), 32'd0);
      check("reset irq", 32'(irq), 32'd0);
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
      rst = 1'b0;
      tick();

      // Reset readback of every word, then register-map vectors while stopped.
      for (int a = 0; a < 64; a += 4) vt.push_back('{1'b0, 6'(a), 32'd0, 4'h0, 32'd0});
      vt.push_back('{1'b1, A_PERIOD, 32'hFFFF0009, 4'hF, 32'h00000009});
      vt.push_back('{1'b1, A_PERIOD, 32'h0000AB00, 4'h2, 32'h0000AB09});
      vt.push_back('{1'b1, A_PERIOD, 32'h00000009, 4'hF, 32'h00000009});
      vt.push_back('{1'b1, A_DUTY0,  32'h00000003, 4'hF, 32'h00000003});
      vt.push_back('{1'b1, A_DUTY1,  32'hDEADBEEF, 4'h3, 32'h0000BEEF});
      vt.push_back('{1'b1, A_DUTY1,  32'h00000000, 4'hF, 32'h00000000});
      vt.push_back('{1'b1, A_DUTY2,  32'h0000000A, 4'hF, 32'h0000000A});
      vt.push_back('{1'b1, 6'h3C,    32'h12345678, 4'hF, 32'h00000000});
      vt.push_back('{1'b1, 6'h20,    32'hFFFFFFFF, 4'hF, 32'h00000000});
      vt.push_back('{1'b1, A_COUNT,  32'h00000055, 4'hF, 32'h00000000});
      vt.push_back('{1'b1, A_STATUS, 32'h00000001, 4'hF, 32'h00000000});
      vt.push_back('{1'b1, A_CTRL,   32'h00000002, 4'hF, {30'd0, HAS_IRQ, 1'b0}});
      vt.push_back('{1'b1, A_CTRL,   32'h00000003, 4'h0, {30'd0, HAS_IRQ, 1'b0}});
      vt.push_back('{1'b1, A_CTRL,   32'h00000000, 4'hF, 32'h00000000});
      for (int i = 0; i < vt.size(); i++) begin
         if (vt[i].wr) axi_write(vt[i].addr, vt[i].wdata, vt[i].strb);
         axi_read(vt[i].addr, d);
         check($sformatf("vec%0d addr 0x%02h", i, vt[i].addr), d, vt[i].exp);
      end

      // PERIOD=9: ch0 3 high / 7 low, ch1 low, ch2 high, ch3 low.
      axi_write(A_CTRL, 32'h1, 4'hF);
      base = cyc;
      for (int i = 0; i < 30; i++) begin
         check($sformatf("pwm run c%0d", i), 32'(pwm_out),
               {28'd0, 1'b0, 1'b1, 1'b0, ((i % 10) < 3)});
         tick();
      end

      // Duty change at the first cycle of a period must wait for the next wrap.
      wait_phase(base, 0, 10, 0);
      axi_write(A_DUTY0, 32'h7, 4'hF);
      duty_now = 3;
      for (int i = 0; i < 20; i++) begin
         if (((cyc - base) % 10) == 0) duty_now = 7;
         check($sformatf("pwm dbuf c%0d", i), 32'(pwm_out),
               {28'd0, 1'b0, 1'b1, 1'b0, (((cyc - base) % 10) < duty_now)});
         tick();
      end

      axi_write(A_CTRL, 32'h0, 4'hF);
      check("pwm after en fall", 32'(pwm_out), 32'd0);
      read_check("count after en fall", A_COUNT, 32'd0);

      // Wrap flag / irq with PERIOD=4.
      axi_write(A_PERIOD, 32'h4, 4'hF);
      axi_write(A_STATUS, 32'h1, 4'hF);
      axi_write(A_CTRL, 32'h3, 4'hF);
      base = cyc;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("irq rise c%0d", i), 32'(irq), (i == 5) ? 32'(HAS_IRQ) : 32'd0);
         tick();
      end
      wait_phase(base, 1, 5, 0);
      axi_write(A_STATUS, 32'h1, 4'hF);
      check("irq after w1c", 32'(irq), 32'd0);
      tick();
      check("irq after w1c +1", 32'(irq), 32'd0);
      read_check("status after w1c", A_STATUS, 32'd0);
      wait_phase(base, 1, 5, 4);
      axi_write(A_STATUS, 32'h1, 4'hF);
      check("irq w1c at wrap", 32'(irq), 32'(HAS_IRQ));
      tick();
      check("irq w1c at wrap +1", 32'(irq), 32'(HAS_IRQ));
      read_check("status w1c at wrap", A_STATUS, {31'd0, HAS_IRQ});

      // Second write held off while BREADY stays low.
      bus.S_AXI_AWADDR = A_DUTY3; bus.S_AXI_WDATA = 32'h11; bus.S_AXI_WSTRB = 4'hF;
      bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b0;
      #1;
      check("bp first awready", 32'(bus.S_AXI_AWREADY), 32'd1);
      tick();
      bus.S_AXI_WDATA = 32'h22;
      #1;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp awready c%0d", i), 32'(bus.S_AXI_AWREADY), 32'd0);
         check($sformatf("bp bvalid c%0d", i), 32'(bus.S_AXI_BVALID), 32'd1);
         tick();
      end
      bus.S_AXI_BREADY = 1'b1;
      tick();
      check("bp second awready", 32'(bus.S_AXI_AWREADY), 32'd1);
      check("bp bvalid dropped", 32'(bus.S_AXI_BVALID), 32'd0);
      tick();
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      check("bp second bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
      tick();
      bus.S_AXI_BREADY = 1'b0;
      read_check("bp duty3", A_DUTY3, 32'h22);

      // PERIOD=0: output is 1 exactly for channels with nonzero duty.
      axi_write(A_CTRL, 32'h0, 4'hF);
      axi_write(A_PERIOD, 32'h0, 4'hF);
      axi_write(A_CTRL, 32'h1, 4'hF);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("period0 pwm c%0d", i), 32'(pwm_out), 32'b1101);
         tick();
      end
      read_check("period0 count", A_COUNT, 32'd0);

      // Reset in the middle of a read data phase.
      bus.S_AXI_ARADDR = A_CTRL; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b0;
      #1;
      check("rst-mid arready", 32'(bus.S_AXI_ARREADY), 32'd1);
      tick();
      bus.S_AXI_ARVALID = 1'b0;
      check("rst-mid rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
      check("rst-mid rdata", bus.S_AXI_RDATA, 32'd1);
      rst = 1'b1;
      tick();
      check("rst-mid rvalid drop", 32'(bus.S_AXI_RVALID), 32'd0);
      check("rst-mid rdata clear", bus.S_AXI_RDATA, 32'd0);
      check("rst-mid pwm", 32'(pwm_out), 32'd0);
      check("rst-mid irq", 32'(irq), 32'd0);
      check("rst-mid bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
      rst = 1'b0;
      tick();
      read_check("post-rst ctrl", A_CTRL, 32'd0);
      read_check("post-rst duty2", A_DUTY2, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
